// File: rtl/commit_batch_eng.sv
// commit_batch_eng
//   Applies an already-parsed VR COMMIT (view, commit opnum) to the replica.
//   The command is first validated against the replica state. Each log entry
//   from last-committed+1 up to min(commit, last_op) then gets its committed
//   flag set by a read-modify-write of the circular log, one entry at a time.
//   At most MAX_BATCH entries are committed per command. The new commit number
//   is then written back to the VR state, and a status is reported.
//
//   Handshake rule, for every val/rdy pair: a transfer happens on the clock
//   edge where both val and rdy are high. Once val is raised it stays high,
//   and its payload stays stable, until that transfer.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_val/cmd_rdy               command handshake
//   cmd_view, cmd_commit_num      view and commit opnum of the COMMIT message
//   state_view                    current replica view
//   state_commit_num              last committed opnum
//   state_last_op                 highest opnum present in the log
//   state_wr_val/rdy              write-back handshake for the new commit number
//   state_wr_commit_num           new commit number
//   log_rd_req_val/rdy            log read request; log_rd_req_addr = slot
//   log_rd_resp_val/rdy           log read response; log_rd_resp_data = entry
//   log_wr_val/rdy                log write; log_wr_addr, log_wr_data
//   done_val/done_rdy             completion handshake
//   done_status                   0 OK, 1 STALE, 2 PARTIAL
//   done_count                    entries committed by this command
//   busy                          high whenever the engine is not idle
module commit_batch_eng #(
   parameter int NOC_DATA_W  = 512,
   parameter int LOG_DEPTH_W = 10,
   parameter int OPNUM_W     = 64,
   parameter int VIEW_W      = 64,
   parameter int MAX_BATCH   = 16,
   parameter int COMMIT_BIT  = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_val,
   output logic                             cmd_rdy,
   input  logic [VIEW_W-1:0]                cmd_view,
   input  logic [OPNUM_W-1:0]               cmd_commit_num,
   input  logic [VIEW_W-1:0]                state_view,
   input  logic [OPNUM_W-1:0]               state_commit_num,
   input  logic [OPNUM_W-1:0]               state_last_op,
   output logic                             state_wr_val,
   input  logic                             state_wr_rdy,
   output logic [OPNUM_W-1:0]               state_wr_commit_num,
   output logic                             log_rd_req_val,
   input  logic                             log_rd_req_rdy,
   output logic [LOG_DEPTH_W-1:0]           log_rd_req_addr,
   input  logic                             log_rd_resp_val,
   output logic                             log_rd_resp_rdy,
   input  logic [NOC_DATA_W-1:0]            log_rd_resp_data,
   output logic                             log_wr_val,
   input  logic                             log_wr_rdy,
   output logic [LOG_DEPTH_W-1:0]           log_wr_addr,
   output logic [NOC_DATA_W-1:0]            log_wr_data,
   output logic                             done_val,
   input  logic                             done_rdy,
   output logic [1:0]                       done_status,
   output logic [$clog2(MAX_BATCH+1)-1:0]   done_count,
   output logic                             busy
);

   localparam int CW = $clog2(MAX_BATCH+1);

   localparam logic [1:0] STATUS_OK      = 2'd0;
   localparam logic [1:0] STATUS_STALE   = 2'd1;
   localparam logic [1:0] STATUS_PARTIAL = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_RD_REQ, ST_RD_RESP, ST_WR, ST_STATE_WR, ST_DONE
   } state_t;

   state_t                 state, state_n;
   logic                   out_en;     // holds cmd_rdy low until the first clock after reset
   logic [VIEW_W-1:0]      view_q;
   logic [OPNUM_W-1:0]     commit_q;
   logic [OPNUM_W-1:0]     target_q;
   logic [OPNUM_W-1:0]     cur_q;      // opnum of the entry being committed
   logic [CW-1:0]          cnt_q;
   logic                   stale_q;
   logic [NOC_DATA_W-1:0]  word_q;

   logic [OPNUM_W-1:0]     target_c;
   logic                   stale_c;
   logic [OPNUM_W-1:0]     cur_inc;
   logic [CW-1:0]          cnt_inc;
   logic                   batch_end;
   logic                   cmd_acc;

   // Validation and loop arithmetic, kept outside the FSM process for readability.
   always_comb begin
      target_c  = (commit_q < state_last_op) ? commit_q : state_last_op;
      stale_c   = (view_q != state_view) || (commit_q <= state_commit_num) ||
                  (target_c <= state_commit_num);
      cur_inc   = cur_q + OPNUM_W'(1);
      cnt_inc   = cnt_q + CW'(1);
      batch_end = (cur_inc > target_q) || (cnt_inc == CW'(MAX_BATCH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n             = state;
      cmd_acc             = 1'b0;
      cmd_rdy             = 1'b0;
      busy                = (state != ST_IDLE);
      log_rd_req_val      = 1'b0;
      log_rd_resp_rdy     = 1'b0;
      log_wr_val          = 1'b0;
      state_wr_val        = 1'b0;
      done_val            = 1'b0;
      log_rd_req_addr     = cur_q[LOG_DEPTH_W-1:0];
      log_wr_addr         = cur_q[LOG_DEPTH_W-1:0];
      log_wr_data         = word_q;
      state_wr_commit_num = '0;
      done_status         = STATUS_OK;
      done_count          = '0;
      case (state)
         ST_IDLE: begin
            cmd_rdy = out_en;
            cmd_acc = out_en && cmd_val;
            if (cmd_acc) state_n = ST_CHECK;
         end
         ST_CHECK: begin
            state_n = stale_c ? ST_DONE : ST_RD_REQ;
         end
         ST_RD_REQ: begin
            log_rd_req_val = 1'b1;
            if (log_rd_req_rdy) state_n = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            log_rd_resp_rdy = 1'b1;
            if (log_rd_resp_val) state_n = ST_WR;
         end
         ST_WR: begin
            log_wr_val = 1'b1;
            if (log_wr_rdy) state_n = batch_end ? ST_STATE_WR : ST_RD_REQ;
         end
         ST_STATE_WR: begin
            state_wr_val        = 1'b1;
            state_wr_commit_num = cur_q - OPNUM_W'(1);
            if (state_wr_rdy) state_n = ST_DONE;
         end
         ST_DONE: begin
            done_val   = 1'b1;
            done_count = cnt_q;
            if (stale_q)
               done_status = STATUS_STALE;
            else if ((cur_q - OPNUM_W'(1)) < target_q)
               done_status = STATUS_PARTIAL;   // stopped by MAX_BATCH, not by target
            else
               done_status = STATUS_OK;
            if (done_rdy) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_en   <= 1'b0;
         view_q   <= '0;
         commit_q <= '0;
         target_q <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         stale_q  <= 1'b0;
         word_q   <= '0;
      end else begin
         out_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cmd_acc) begin
                  view_q   <= cmd_view;
                  commit_q <= cmd_commit_num;
               end
            end
            ST_CHECK: begin
               cnt_q    <= '0;
               stale_q  <= stale_c;
               target_q <= target_c;
               cur_q    <= state_commit_num + OPNUM_W'(1);
            end
            ST_RD_RESP: begin
               if (log_rd_resp_val) begin
                  word_q             <= log_rd_resp_data;
                  word_q[COMMIT_BIT] <= 1'b1;   // later NBA wins for this bit only
               end
            end
            ST_WR: begin
               if (log_wr_rdy) begin
                  cnt_q <= cnt_inc;
                  cur_q <= cur_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_batch_eng.sv
module tb_commit_batch_eng;

   localparam int DW   = 64;
   localparam int AW   = 4;
   localparam int OW   = 64;
   localparam int VW   = 64;
   localparam int MB   = 16;
   localparam int CB   = 5;
   localparam int CW   = $clog2(MB+1);
   localparam int SLOTS = 1 << AW;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_val = 1'b0;
   logic          cmd_rdy;
   logic [VW-1:0] cmd_view = '0;
   logic [OW-1:0] cmd_commit_num = '0;
   logic [VW-1:0] st_view = '0;
   logic [OW-1:0] st_commit = '0;
   logic [OW-1:0] st_last = '0;
   logic          state_wr_val;
   logic          state_wr_rdy = 1'b0;
   logic [OW-1:0] state_wr_commit_num;
   logic          log_rd_req_val;
   logic          log_rd_req_rdy = 1'b0;
   logic [AW-1:0] log_rd_req_addr;
   logic          log_rd_resp_val = 1'b0;
   logic          log_rd_resp_rdy;
   logic [DW-1:0] log_rd_resp_data = '0;
   logic          log_wr_val;
   logic          log_wr_rdy = 1'b0;
   logic [AW-1:0] log_wr_addr;
   logic [DW-1:0] log_wr_data;
   logic          done_val;
   logic          done_rdy = 1'b0;
   logic [1:0]    done_status;
   logic [CW-1:0] done_count;
   logic          busy;

   commit_batch_eng #(
      .NOC_DATA_W(DW), .LOG_DEPTH_W(AW), .OPNUM_W(OW), .VIEW_W(VW),
      .MAX_BATCH(MB), .COMMIT_BIT(CB)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
      .cmd_view(cmd_view), .cmd_commit_num(cmd_commit_num),
      .state_view(st_view), .state_commit_num(st_commit), .state_last_op(st_last),
      .state_wr_val(state_wr_val), .state_wr_rdy(state_wr_rdy),
      .state_wr_commit_num(state_wr_commit_num),
      .log_rd_req_val(log_rd_req_val), .log_rd_req_rdy(log_rd_req_rdy),
      .log_rd_req_addr(log_rd_req_addr),
      .log_rd_resp_val(log_rd_resp_val), .log_rd_resp_rdy(log_rd_resp_rdy),
      .log_rd_resp_data(log_rd_resp_data),
      .log_wr_val(log_wr_val), .log_wr_rdy(log_wr_rdy),
      .log_wr_addr(log_wr_addr), .log_wr_data(log_wr_data),
      .done_val(done_val), .done_rdy(done_rdy),
      .done_status(done_status), .done_count(done_count),
      .busy(busy)
   );

   // scoreboard
   int checks = 0;
   int errors = 0;

   logic [AW-1:0] exp_ra_q[$];
   logic [AW-1:0] exp_wa_q[$];
   logic [DW-1:0] exp_wd_q[$];
   logic [OW-1:0] exp_sw_q[$];

   logic [DW-1:0] log_mem[SLOTS];   // the log the DUT talks to
   logic [DW-1:0] ref_mem[SLOTS];   // reference view of the log
   int            wr_count = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave side of the log and state ports. Everything happens on the falling
   // edge: ready/valid for the next rising edge are chosen, and transfers that
   // will occur on that edge are remembered and retired one negedge later
   // (discarded if reset arrived in between).
   initial begin : responder
      bit            rq_fire = 0, rs_fire = 0, wr_fire = 0, sw_fire = 0;
      bit            pend = 0;
      logic [AW-1:0] pend_addr = '0, rq_addr = '0, wr_addr_s = '0;
      logic [DW-1:0] wr_data_s = '0;
      logic [OW-1:0] sw_s = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            log_rd_req_rdy  = 1'b0;
            log_wr_rdy      = 1'b0;
            state_wr_rdy    = 1'b0;
            log_rd_resp_val = 1'b0;
            pend    = 0;
            rq_fire = 0; rs_fire = 0; wr_fire = 0; sw_fire = 0;
         end else begin
            if (rq_fire) begin
               if (exp_ra_q.size() == 0) check("rd_unexpected", 64'(exp_ra_q.size()), 64'd1);
               else check("rd_addr", 64'(rq_addr), 64'(exp_ra_q.pop_front()));
               pend      = 1;
               pend_addr = rq_addr;
            end
            if (rs_fire) begin
               log_rd_resp_val = 1'b0;
               pend            = 0;
            end
            if (wr_fire) begin
               if (exp_wa_q.size() == 0) begin
                  check("wr_unexpected", 64'(exp_wa_q.size()), 64'd1);
               end else begin
                  check("wr_addr", 64'(wr_addr_s), 64'(exp_wa_q.pop_front()));
                  check("wr_data", wr_data_s, exp_wd_q.pop_front());
               end
               log_mem[wr_addr_s] = wr_data_s;
               wr_count++;
            end
            if (sw_fire) begin
               if (exp_sw_q.size() == 0) check("sw_unexpected", 64'(exp_sw_q.size()), 64'd1);
               else check("state_wr_num", sw_s, exp_sw_q.pop_front());
            end
            log_rd_req_rdy = 1'($urandom_range(0, 1));
            log_wr_rdy     = 1'($urandom_range(0, 1));
            state_wr_rdy   = 1'($urandom_range(0, 1));
            if (pend && !log_rd_resp_val && $urandom_range(0, 2) != 0) begin
               log_rd_resp_val  = 1'b1;
               log_rd_resp_data = log_mem[pend_addr];
            end
            rq_fire   = log_rd_req_val && log_rd_req_rdy;
            rq_addr   = log_rd_req_addr;
            rs_fire   = log_rd_resp_val && log_rd_resp_rdy;
            wr_fire   = log_wr_val && log_wr_rdy;
            wr_addr_s = log_wr_addr;
            wr_data_s = log_wr_data;
            sw_fire   = state_wr_val && state_wr_rdy;
            sw_s      = state_wr_commit_num;
         end
      end
   end

   // Reference model: what a COMMIT should do to the log and state, in terms
   // of the replica rules (min, counts, list of opnums).
   task automatic expect_cmd(input logic [VW-1:0] cv, input logic [OW-1:0] cc,
                             output logic [1:0] est, output int ecnt,
                             output logic [OW-1:0] enew);
      logic [OW-1:0] target, op, n;
      logic [AW-1:0] slot;
      logic [DW-1:0] d;
      target = (cc < st_last) ? cc : st_last;
      enew   = st_commit;
      if (cv != st_view || cc <= st_commit || target <= st_commit) begin
         est  = 2'd1;
         ecnt = 0;
      end else begin
         n = target - st_commit;
         if (n > OW'(MB)) n = OW'(MB);
         for (int i = 1; i <= int'(n); i++) begin
            op   = st_commit + OW'(i);
            slot = op[AW-1:0];
            d    = ref_mem[slot] | (DW'(1) << CB);
            ref_mem[slot] = d;
            exp_ra_q.push_back(slot);
            exp_wa_q.push_back(slot);
            exp_wd_q.push_back(d);
         end
         enew = st_commit + n;
         exp_sw_q.push_back(enew);
         est  = (enew < target) ? 2'd2 : 2'd0;
         ecnt = int'(n);
      end
   endtask

   // driver tasks (called on a falling edge)
   task automatic send_cmd(input logic [VW-1:0] cv, input logic [OW-1:0] cc);
      bit ok = 0;
      cmd_val        = 1'b1;
      cmd_view       = cv;
      cmd_commit_num = cc;
      for (int i = 0; i < 200; i++) begin
         if (cmd_rdy) begin
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      cmd_val = 1'b0;
      check("cmd_accepted", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input logic [1:0] est, input int ecnt);
      bit got = 0;
      for (int i = 0; i < 4000; i++) begin
         if (done_val) begin
            done_rdy = 1'($urandom_range(0, 1));
            if (done_rdy) begin
               check("done_status", 64'(done_status), 64'(est));
               check("done_count", 64'(done_count), 64'(ecnt));
               got = 1;
               @(negedge clk);
               done_rdy = 1'b0;
               break;
            end
         end
         @(negedge clk);
      end
      check("done_seen", 64'(got), 64'd1);
      check("rd_left", 64'(exp_ra_q.size()), 64'd0);
      check("wr_left", 64'(exp_wa_q.size()), 64'd0);
      check("sw_left", 64'(exp_sw_q.size()), 64'd0);
      check("idle_after", 64'(busy), 64'd0);
   endtask

   task automatic run_cmd(input logic [VW-1:0] cv, input logic [OW-1:0] cc);
      logic [1:0]    est;
      int            ecnt;
      logic [OW-1:0] enew;
      expect_cmd(cv, cc, est, ecnt, enew);
      send_cmd(cv, cc);
      wait_done(est, ecnt);
      st_commit = enew;   // the replica applies the written-back commit number
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_rd_req_val"}, 64'(log_rd_req_val), 64'd0);
      check({tag, "_wr_val"}, 64'(log_wr_val), 64'd0);
      check({tag, "_state_wr_val"}, 64'(state_wr_val), 64'd0);
      check({tag, "_done_val"}, 64'(done_val), 64'd0);
      check({tag, "_resp_rdy"}, 64'(log_rd_resp_rdy), 64'd0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog elapsed_ns=%0t limit_ns=5000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [1:0]    est;
      int            ecnt;
      logic [OW-1:0] enew;
      int            base;
      bit            hit;
      for (int i = 0; i < SLOTS; i++) begin
         log_mem[i] = {$urandom(), $urandom()};
         ref_mem[i] = log_mem[i];
      end

      // reset values, before any clock edge
      #1;
      check_quiet("rst");
      check("rst_sw_num", state_wr_commit_num, 64'd0);
      check("rst_wr_data", log_wr_data, 64'd0);
      check("rst_rd_addr", 64'(log_rd_req_addr), 64'd0);
      check("rst_done_cnt", 64'(done_count), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
      @(negedge clk);
      check("rel_cmd_rdy_high", 64'(cmd_rdy), 64'd1);

      // basic commit of 11..13
      st_view = 5; st_commit = 10; st_last = 20;
      run_cmd(5, 13);
      // stale: wrong view, then no progress
      st_commit = 10;
      run_cmd(4, 13);
      run_cmd(5, 10);
      // batch limit
      st_commit = 10; st_last = 50;
      run_cmd(5, 40);
      check("t3_commit", st_commit, 64'd26);
      // slot wrap
      st_commit = 14; st_last = 50;
      run_cmd(5, 18);
      check("t4_commit", st_commit, 64'd18);
      // clamp to last_op
      st_commit = 10; st_last = 12;
      run_cmd(5, 30);
      check("t5_commit", st_commit, 64'd12);

      // random commands
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 5) == 0) st_view = VW'($urandom_range(0, 3));
         st_last = st_commit + OW'($urandom_range(0, 20));
         run_cmd(($urandom_range(0, 4) == 0) ? st_view + 1 : st_view,
                 st_commit - 2 + OW'($urandom_range(0, 26)));
      end

      // reset in the middle of a log write, then recover
      st_view = 5; st_commit = 100; st_last = 115;
      expect_cmd(5, 112, est, ecnt, enew);
      base = wr_count;
      send_cmd(5, 112);
      hit = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (wr_count >= base + 3 && log_wr_val) begin
            hit = 1;
            break;
         end
      end
      check("t6_wr_reached", 64'(hit), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("t6_rst");
      repeat (2) @(negedge clk);
      exp_ra_q.delete();
      exp_wa_q.delete();
      exp_wd_q.delete();
      exp_sw_q.delete();
      for (int i = 0; i < SLOTS; i++) ref_mem[i] = log_mem[i];
      rst = 1'b0;
      @(negedge clk);
      check("t6_cmd_rdy", 64'(cmd_rdy), 64'd1);
      run_cmd(5, 112);
      check("t6_commit", st_commit, 64'd112);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
